// File: rtl/axis_snapshot_pkg.sv
// rtl/axis_snapshot_pkg.sv - state encoding and shared widths for the stream snapshot controller
package axis_snapshot_pkg;

  localparam int unsigned STATE_WIDTH  = 3;
  localparam int unsigned TSTAMP_WIDTH = 64;

  typedef enum logic [STATE_WIDTH-1:0] {
    S_IDLE    = 3'd0,
    S_ARMED   = 3'd1,
    S_DELAY   = 3'd2,
    S_CAPTURE = 3'd3,
    S_DONE    = 3'd4
  } state_e;

endpackage

// File: rtl/axis_snapshot_trig_edge.sv
// rtl/axis_snapshot_trig_edge.sv - rising-edge detector for the aclk-synchronous trigger input
module axis_snapshot_trig_edge (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic trig_i,
  output logic edge_o
);

  logic trig_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      trig_q <= 1'b0;
    end else begin
      trig_q <= trig_i;
    end
  end

  assign edge_o = trig_i & ~trig_q;

endmodule

// File: rtl/axis_snapshot_ctrl.sv
// rtl/axis_snapshot_ctrl.sv - arm/trigger/delay sequencer that latches one stream beat for readout
// SNAPSHOT_TSTAMP_EN adds a free-running cycle counter and the snap_tstamp output.
module axis_snapshot_ctrl
  import axis_snapshot_pkg::*;
#(
  parameter int unsigned AXIS_TDATA_WIDTH = 32,
  parameter int unsigned CNTR_WIDTH       = 32,
  parameter int unsigned COUNT_WIDTH      = 16
) (
  input  logic                        aclk,
  input  logic                        aresetn,
  input  logic                        cfg_arm,
  input  logic                        cfg_abort,
  input  logic                        cfg_auto,
  input  logic [CNTR_WIDTH-1:0]       cfg_delay,
  input  logic                        trig_in,
  input  logic [AXIS_TDATA_WIDTH-1:0] s_axis_tdata,
  input  logic                        s_axis_tvalid,
  output logic                        s_axis_tready,
  output logic [AXIS_TDATA_WIDTH-1:0] snap_data,
  output logic                        snap_valid,
  output logic                        snap_strobe,
  output logic [COUNT_WIDTH-1:0]      snap_count,
  output logic                        busy
`ifdef SNAPSHOT_TSTAMP_EN
  ,
  output logic [TSTAMP_WIDTH-1:0]     snap_tstamp
`endif
);

  state_e                      state_q;
  logic [CNTR_WIDTH-1:0]       delay_cnt_q;
  logic [AXIS_TDATA_WIDTH-1:0] snap_data_q;
  logic                        snap_valid_q;
  logic                        snap_strobe_q;
  logic [COUNT_WIDTH-1:0]      snap_count_q;
  logic [COUNT_WIDTH-1:0]      snap_count_d;
  logic                        trig_edge;

  axis_snapshot_trig_edge u_trig_edge (
    .clk_i  (aclk),
    .rst_ni (aresetn),
    .trig_i (trig_in),
    .edge_o (trig_edge)
  );

  assign snap_count_d = snap_count_q + COUNT_WIDTH'(1);

  // Abort has priority over every state transition, including a same-cycle arm or capture.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q       <= S_IDLE;
      delay_cnt_q   <= '0;
      snap_data_q   <= '0;
      snap_valid_q  <= 1'b0;
      snap_strobe_q <= 1'b0;
      snap_count_q  <= '0;
    end else begin
      snap_strobe_q <= 1'b0;
      if (cfg_abort) begin
        state_q <= S_IDLE;
      end else begin
        case (state_q)
          S_IDLE: begin
            if (cfg_arm) begin
              state_q      <= S_ARMED;
              snap_valid_q <= 1'b0;
            end
          end
          S_ARMED: begin
            if (trig_edge) begin
              delay_cnt_q <= cfg_delay;
              state_q     <= (cfg_delay == '0) ? S_CAPTURE : S_DELAY;
            end
          end
          S_DELAY: begin
            delay_cnt_q <= delay_cnt_q - CNTR_WIDTH'(1);
            if (delay_cnt_q == CNTR_WIDTH'(1)) begin
              state_q <= S_CAPTURE;
            end
          end
          S_CAPTURE: begin
            if (s_axis_tvalid) begin
              snap_data_q   <= s_axis_tdata;
              snap_valid_q  <= 1'b1;
              snap_count_q  <= snap_count_d;
              snap_strobe_q <= 1'b1;
              state_q       <= S_DONE;
            end
          end
          S_DONE: begin
            state_q <= cfg_auto ? S_ARMED : S_IDLE;
          end
          default: begin
            state_q <= S_IDLE;
          end
        endcase
      end
    end
  end

`ifdef SNAPSHOT_TSTAMP_EN
  logic [TSTAMP_WIDTH-1:0] tstamp_q;
  logic [TSTAMP_WIDTH-1:0] snap_tstamp_q;
  logic                    capture;

  assign capture = (state_q == S_CAPTURE) && s_axis_tvalid && !cfg_abort;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      tstamp_q      <= '0;
      snap_tstamp_q <= '0;
    end else begin
      tstamp_q <= tstamp_q + TSTAMP_WIDTH'(1);
      if (capture) begin
        snap_tstamp_q <= tstamp_q;
      end
    end
  end

  assign snap_tstamp = snap_tstamp_q;
`endif

  assign s_axis_tready = 1'b1;
  assign snap_data     = snap_data_q;
  assign snap_valid    = snap_valid_q;
  assign snap_strobe   = snap_strobe_q;
  assign snap_count    = snap_count_q;
  assign busy          = (state_q != S_IDLE);

endmodule

// File: tb/tb_axis_snapshot_ctrl.sv
// tb/tb_axis_snapshot_ctrl.sv - randomized self-checking bench for axis_snapshot_ctrl
module tb_axis_snapshot_ctrl;

  localparam int DW = 32;
  localparam int NW = 32;
  localparam int CW = 4;

  logic          aclk = 1'b0;
  logic          aresetn = 1'b0;
  logic          cfg_arm = 1'b0;
  logic          cfg_abort = 1'b0;
  logic          cfg_auto = 1'b0;
  logic [NW-1:0] cfg_delay = '0;
  logic          trig_in = 1'b0;
  logic [DW-1:0] s_axis_tdata = '0;
  logic          s_axis_tvalid = 1'b0;
  logic          s_axis_tready;
  logic [DW-1:0] snap_data;
  logic          snap_valid;
  logic          snap_strobe;
  logic [CW-1:0] snap_count;
  logic          busy;

  always #5 aclk = ~aclk;

  axis_snapshot_ctrl #(
    .AXIS_TDATA_WIDTH (DW),
    .CNTR_WIDTH       (NW),
    .COUNT_WIDTH      (CW)
  ) dut (
    .aclk          (aclk),
    .aresetn       (aresetn),
    .cfg_arm       (cfg_arm),
    .cfg_abort     (cfg_abort),
    .cfg_auto      (cfg_auto),
    .cfg_delay     (cfg_delay),
    .trig_in       (trig_in),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .snap_data     (snap_data),
    .snap_valid    (snap_valid),
    .snap_strobe   (snap_strobe),
    .snap_count    (snap_count),
    .busy          (busy)
  );

  int            checks = 0;
  int            failures = 0;
  int            cyc = 0;
  bit            vld_log [32768];
  logic [DW-1:0] dat_log [32768];
  logic [CW-1:0] model_count = '0;
  logic [DW-1:0] model_data = '0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic bit rv(input int pct);
    return $urandom_range(99) < pct;
  endfunction

  // Drive one cycle's inputs just after the rising edge, then return at the falling edge.
  task automatic step(input bit arm, input bit abort, input bit trig, input bit vld);
    @(posedge aclk);
    #1;
    cyc++;
    cfg_arm       = arm;
    cfg_abort     = abort;
    trig_in       = trig;
    s_axis_tvalid = vld;
    s_axis_tdata  = $urandom;
    vld_log[cyc]  = vld;
    dat_log[cyc]  = s_axis_tdata;
    @(negedge aclk);
  endtask

  // One snapshot: expected capture is the first valid beat at or after trigger cycle + 1 + delay.
  task automatic snap(input int d, input int pct, input int quiet, input bit do_arm, input bit auto_en);
    int t;
    int s;
    int c;
    int h;
    bit busy_ok;
    cfg_auto  = auto_en;
    cfg_delay = NW'(d);
    busy_ok   = 1'b1;
    if (do_arm) begin
      step(1, 0, 0, rv(pct));
      step(0, 0, 0, rv(pct));
      check_eq("arm_valid_clr", snap_valid, 0);
      check_eq("arm_busy", busy, 1);
    end
    repeat ($urandom_range(3)) step(0, 0, 0, rv(pct));
    h = $urandom_range(1, 3);
    t = cyc + 1;
    s = -1;
    for (int n = 0; n < d + quiet + 200 && s < 0; n++) begin
      int k;
      bit tr;
      bit v;
      k  = cyc + 1;
      tr = (k - t < h) || (d >= 4 && k - t == h + 1);
      v  = (k >= t + 1 + d && k < t + 1 + d + quiet) ? 1'b0 : rv(pct);
      if (k == t + 2) cfg_delay = $urandom;
      step(0, 0, tr, v);
      if (snap_strobe) s = cyc;
      else if (!busy) busy_ok = 1'b0;
    end
    if (s < 0) begin
      check_eq("capture_timeout", 0, 1);
    end else begin
      c = -1;
      for (int n = t + 1 + d; n < s && c < 0; n++) begin
        if (vld_log[n]) c = n;
      end
      check_eq("strobe_cycle", s, c + 1);
      model_count = model_count + CW'(1);
      model_data  = (c >= 0) ? dat_log[c] : 32'hDEAD_BEEF;
      check_eq("snap_data", snap_data, model_data);
      check_eq("snap_count", snap_count, model_count);
      check_eq("snap_valid", snap_valid, 1);
      check_eq("busy_held", busy_ok, 1);
      step(0, 0, 0, rv(pct));
      check_eq("strobe_pulse", snap_strobe, 0);
      check_eq("busy_after_done", busy, auto_en);
    end
  endtask

  task automatic do_abort();
    step(0, 1, 0, 1);
    step(0, 0, 0, 1);
    check_eq("abort_idle", busy, 0);
  endtask

  initial begin
    int nstrobe;
    int t;
    repeat (3) @(posedge aclk);
    @(negedge aclk);
    check_eq("rst_data", snap_data, 0);
    check_eq("rst_valid", snap_valid, 0);
    check_eq("rst_strobe", snap_strobe, 0);
    check_eq("rst_count", snap_count, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("tready", s_axis_tready, 1);
    aresetn = 1'b1;

    snap(0, 100, 0, 1, 0);
    snap(5, 100, 0, 1, 0);
    snap(3, 100, 20, 1, 0);
    snap(1, 50, 0, 1, 0);

    snap(2, 80, 0, 1, 1);
    snap(2, 80, 0, 0, 1);
    snap(2, 80, 0, 0, 1);
    check_eq("auto_armed_busy", busy, 1);
    check_eq("auto_valid_kept", snap_valid, 1);
    do_abort();

    // Arm and abort together: abort wins, so the held capture stays valid.
    step(1, 1, 0, 0);
    step(0, 0, 0, 0);
    check_eq("armabort_idle", busy, 0);
    check_eq("armabort_valid", snap_valid, 1);

    cfg_auto  = 1'b0;
    cfg_delay = 10;
    step(1, 0, 0, 1);
    step(0, 0, 1, 1);
    step(0, 0, 1, 1);
    step(0, 0, 0, 1);
    step(0, 0, 0, 1);
    do_abort();
    nstrobe = 0;
    for (int n = 0; n < 20; n++) begin
      step(0, 0, (n % 4) == 1, 1);
      if (snap_strobe) nstrobe++;
    end
    check_eq("abort_no_strobe", nstrobe, 0);
    check_eq("abort_count", snap_count, model_count);
    check_eq("abort_data", snap_data, model_data);
    check_eq("abort_valid", snap_valid, 0);

    // Held-high trigger in auto mode produces a single capture.
    cfg_auto  = 1'b1;
    cfg_delay = 2;
    step(1, 0, 0, 1);
    t = cyc + 1;
    nstrobe = 0;
    for (int n = 0; n < 40; n++) begin
      step(0, 0, 1, 1);
      if (snap_strobe) nstrobe++;
    end
    check_eq("held_trig_strobes", nstrobe, 1);
    model_count = model_count + CW'(1);
    model_data  = dat_log[t + 3];
    check_eq("held_trig_data", snap_data, model_data);
    check_eq("held_trig_count", snap_count, model_count);
    do_abort();

    for (int r = 0; r < 12; r++) begin
      int pcts [3];
      pcts = '{100, 60, 25};
      snap($urandom_range(0, 12), pcts[$urandom_range(2)], ($urandom_range(3) == 0) ? $urandom_range(1, 15) : 0, 1, 0);
    end

    cfg_auto  = 1'b0;
    cfg_delay = 20;
    step(1, 0, 0, 1);
    step(0, 0, 1, 1);
    repeat (5) step(0, 0, 0, 1);
    #2 aresetn = 1'b0;
    #1;
    check_eq("midrst_data", snap_data, 0);
    check_eq("midrst_valid", snap_valid, 0);
    check_eq("midrst_strobe", snap_strobe, 0);
    check_eq("midrst_count", snap_count, 0);
    check_eq("midrst_busy", busy, 0);
    cfg_arm = 1'b0;
    trig_in = 1'b0;
    s_axis_tvalid = 1'b0;
    @(negedge aclk);
    @(negedge aclk);
    aresetn = 1'b1;
    model_count = '0;
    model_data  = '0;

    snap($urandom_range(0, 3), 90, 0, 1, 1);
    for (int r = 0; r < 16; r++) snap($urandom_range(0, 3), 90, 0, 0, 1);
    check_eq("wrap_count", snap_count, 1);
    do_abort();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
